// File: rtl/axi_ar_arbiter.sv
// rtl/axi_ar_arbiter.sv - per-target AR arbiter holding the grant until RLAST
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module axi_ar_arbiter #(
  parameter int REQ_NUM = 4
) (
  input  logic                   AXI_CLK_i,
  input  logic                   AXI_RST_i,
  input  logic [REQ_NUM-1:0]     REQ_VALID_i,
  input  logic [REQ_NUM*49-1:0]  REQ_AR_i,
  output logic [REQ_NUM-1:0]     REQ_POP_o,
  output logic [7:0]             ARID_o,
  output logic [31:0]            ARADDR_o,
  output logic [3:0]             ARLEN_o,
  output logic [2:0]             ARSIZE_o,
  output logic [1:0]             ARBURST_o,
  output logic                   ARVALID_o,
  input  logic                   ARREADY_i,
  input  logic                   RVALID_i,
  input  logic                   RREADY_i,
  input  logic                   RLAST_i,
  output logic [REQ_NUM-1:0]     R_SEL_o,
  output logic                   BUSY_o
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]         state;
  logic [REQ_NUM-1:0] grant_q;
  logic [48:0]        ar_q;

  logic               win_any;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [48:0]        win_ar;

`ifdef AXI_ARB_RR_EN
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;

  // Search begins one past the last granted requester and wraps.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= REQ_NUM; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % REQ_NUM);
      if (!win_any && REQ_VALID_i[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end
`else
  // Descending scan so the lowest requesting index is the last to assign.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (REQ_VALID_i[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end
`endif

  always_comb begin
    win_ar = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (IDX_W'(k) == win_idx) begin
        win_ar = REQ_AR_i[k*49 +: 49];
      end
    end
  end

  always_ff @(posedge AXI_CLK_i) begin
    if (AXI_RST_i) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      ar_q    <= '0;
`ifdef AXI_ARB_RR_EN
      rr_ptr    <= IDX_W'(REQ_NUM - 1);
      grant_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            state   <= ST_ADDR;
            grant_q <= REQ_NUM'(1) << win_idx;
            ar_q    <= win_ar;
`ifdef AXI_ARB_RR_EN
            grant_idx <= win_idx;
`endif
          end
        end
        ST_ADDR: begin
          if (ARREADY_i) begin
            state <= ST_DATA;
`ifdef AXI_ARB_RR_EN
            rr_ptr <= grant_idx;
`endif
          end
        end
        ST_DATA: begin
          if (RVALID_i && RREADY_i && RLAST_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Payload is already packed {id, addr, len, size, burst} upstream.
  assign {ARID_o, ARADDR_o, ARLEN_o, ARSIZE_o, ARBURST_o} = ar_q;

  assign ARVALID_o = (state == ST_ADDR);
  assign BUSY_o    = (state != ST_IDLE);
  assign R_SEL_o   = (state == ST_DATA) ? grant_q : '0;
  // Reset wins over a coincident handshake so an abandoned request is never popped.
  assign REQ_POP_o = ((state == ST_ADDR) && ARREADY_i && !AXI_RST_i) ? grant_q : '0;

endmodule
